// File: rtl/conv_pass_sched.sv
// rtl/conv_pass_sched.sv - conv pass scheduler: channel-inner/filter-outer pass sequencing
// Optional WAIT watchdog enabled by defining SCHED_TIMEOUT_EN.
module conv_pass_sched #(
    parameter int FW      = 4,
    parameter int CW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] num_filters,
    input  logic [CW-1:0] num_channels,
    input  logic          conv_done,
    output logic          conv_go,
    output logic [FW-1:0] filt_bank,
    output logic [CW-1:0] chan_sel,
    output logic          acc_keep,
    output logic          wb_en,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_ADV    = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [FW-1:0] nf_q, nf_d;
    logic [CW-1:0] nc_q, nc_d;
    logic          accept;
    logic          timeout_hit;

    // Abort outranks start, so a simultaneous start/abort in IDLE is dropped.
    assign accept = (state_q == S_IDLE) && start && !abort;

`ifdef SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;

    assign timeout_hit = (wcnt_q == TW'(TIMEOUT - 1));

    // Counter is zero in every state but WAIT, so it starts fresh on each WAIT entry.
    always_comb begin
        wcnt_d = '0;
        if (state_q == S_WAIT) begin
            wcnt_d = wcnt_q + TW'(1);
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == S_WAIT && !conv_done && !abort && timeout_hit) begin
            err_d = 1'b1;
        end else if (accept) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        chan_d  = chan_q;
        nf_d    = nf_q;
        nc_d    = nc_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    nf_d    = num_filters;
                    nc_d    = num_channels;
                    filt_d  = '0;
                    chan_d  = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (conv_done) begin
                    state_d = S_ADV;
                end else if (timeout_hit) begin
                    filt_d  = '0;
                    chan_d  = '0;
                    state_d = S_IDLE;
                end
            end
            S_ADV: begin
                if (chan_q < nc_q) begin
                    chan_d  = chan_q + CW'(1);
                    state_d = S_LAUNCH;
                end else if (filt_q < nf_q) begin
                    chan_d  = '0;
                    filt_d  = filt_q + FW'(1);
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                filt_d  = '0;
                chan_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                filt_d  = '0;
                chan_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        if (abort && state_q != S_IDLE) begin
            filt_d  = '0;
            chan_d  = '0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            filt_q  <= '0;
            chan_q  <= '0;
            nf_q    <= '0;
            nc_q    <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            chan_q  <= chan_d;
            nf_q    <= nf_d;
            nc_q    <= nc_d;
        end
    end

    // wb_en is qualified by busy so the idle compare of two zeroed registers stays low.
    assign conv_go   = (state_q == S_LAUNCH);
    assign done      = (state_q == S_FIN);
    assign busy      = (state_q != S_IDLE);
    assign filt_bank = filt_q;
    assign chan_sel  = chan_q;
    assign acc_keep  = (chan_q != '0);
    assign wb_en     = busy && (chan_q == nc_q);

endmodule

// File: tb/tb_conv_pass_sched.sv
// tb/tb_conv_pass_sched.sv - scoreboard bench for conv_pass_sched
module tb_conv_pass_sched;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] num_filters;
    logic [3:0] num_channels;
    logic       conv_done;
    logic       conv_go;
    logic [3:0] filt_bank;
    logic [3:0] chan_sel;
    logic       acc_keep;
    logic       wb_en;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       kind;
        logic [3:0] f;
        logic [3:0] c;
        logic       ak;
        logic       wb;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    conv_pass_sched #(.FW(4), .CW(4), .TIMEOUT(255)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .num_filters  (num_filters),
        .num_channels (num_channels),
        .conv_done    (conv_done),
        .conv_go      (conv_go),
        .filt_bank    (filt_bank),
        .chan_sel     (chan_sel),
        .acc_keep     (acc_keep),
        .wb_en        (wb_en),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_go(input int f, input int c, input int nc);
        ev_t e;
        e.kind = 1'b0;
        e.f    = 4'(f);
        e.c    = 4'(c);
        e.ak   = (c != 0);
        e.wb   = (c == nc);
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e = '0;
        e.kind = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: every conv_go/done pulse is matched against the next expected event.
    always @(negedge clk) begin
        if (rst_n && (conv_go || done)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: go=%0b done=%0b f=%0d c=%0d with empty queue at %0t",
                         conv_go, done, filt_bank, chan_sel, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_kind", {31'd0, done}, {31'd0, mon_e.kind});
                if (!mon_e.kind) begin
                    chk("go_filt", {28'd0, filt_bank}, {28'd0, mon_e.f});
                    chk("go_chan", {28'd0, chan_sel}, {28'd0, mon_e.c});
                    chk("go_acc_keep", {31'd0, acc_keep}, {31'd0, mon_e.ak});
                    chk("go_wb_en", {31'd0, wb_en}, {31'd0, mon_e.wb});
                end
            end
        end
    end

    // Full layer, cycle exact: conv_done is raised after `gap` WAIT cycles of each pass.
    task automatic run_layer(input int nf, input int nc, input int gap, input bit poke_start);
        num_filters  = 4'(nf);
        num_channels = 4'(nc);
        for (int f = 0; f <= nf; f++)
            for (int c = 0; c <= nc; c++)
                push_go(f, c, nc);
        push_done();
        start = 1'b1;
        tick();
        start = 1'b0;
        num_filters  = ~num_filters;
        num_channels = ~num_channels;
        chk("err_after_start", {31'd0, err}, 32'd0);
        for (int f = 0; f <= nf; f++) begin
            for (int c = 0; c <= nc; c++) begin
                chk("go_launch", {31'd0, conv_go}, 32'd1);
                tick();
                chk("wait_busy", {31'd0, busy}, 32'd1);
                for (int g = 0; g < gap; g++) begin
                    if (poke_start && g == 0) start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                conv_done = 1'b1;
                tick();
                conv_done = 1'b0;
                chk("adv_quiet", {31'd0, conv_go | done}, 32'd0);
                tick();
            end
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        conv_done    = 1'b0;
        num_filters  = 4'd0;
        num_channels = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {24'd0, conv_go, done, busy, acc_keep, wb_en, err, filt_bank != 0, chan_sel != 0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // single pass: start c0, go c1, conv_done c10, done c12
        run_layer(0, 0, 8, 1'b0);

        // 2 filters x 3 channels with a start poked mid-WAIT
        run_layer(1, 2, 3, 1'b1);

        // conv_done in IDLE is ignored
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        chk("idle_conv_done_busy", {31'd0, busy}, 32'd0);
        chk("idle_conv_done_go", {31'd0, conv_go}, 32'd0);

        // abort together with start in IDLE wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", {31'd0, busy}, 32'd0);
        chk("abort_start_go", {31'd0, conv_go}, 32'd0);

        // abort with a coincident conv_done during the second WAIT
        num_filters  = 4'd1;
        num_channels = 4'd1;
        push_go(0, 0, 1);
        push_go(0, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        tick();
        tick();
        abort     = 1'b1;
        conv_done = 1'b1;
        tick();
        abort     = 1'b0;
        conv_done = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_filt", {28'd0, filt_bank}, 32'd0);
        chk("abort_chan", {28'd0, chan_sel}, 32'd0);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        tick();
        chk("abort_no_done_late", {31'd0, done | conv_go}, 32'd0);
        run_layer(2, 0, 1, 1'b0);

        // asynchronous reset in the second WAIT
        num_filters  = 4'd2;
        num_channels = 4'd2;
        push_go(0, 0, 2);
        push_go(0, 1, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        tick();
        tick();
        chk("pre_rst_acc_keep", {31'd0, acc_keep}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {24'd0, conv_go, done, busy, acc_keep, wb_en, err, filt_bank != 0, chan_sel != 0}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_done", {31'd0, done | busy}, 32'd0);
        run_layer(1, 1, 0, 1'b0);

        // both counts at maximum
        run_layer(15, 15, 0, 1'b0);

`ifdef SCHED_TIMEOUT_EN
        num_filters  = 4'd0;
        num_channels = 4'd0;
        push_go(0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (254) tick();
        chk("wd_still_wait", {30'd0, busy, err}, 32'd2);
        tick();
        chk("wd_err_set", {31'd0, err}, 32'd1);
        chk("wd_idle", {31'd0, busy}, 32'd0);
        chk("wd_no_done", {31'd0, done}, 32'd0);
        run_layer(0, 0, 2, 1'b0);
`endif

        tick();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_pass_sched.md
CONV_PASS_SCHED -- requirements
Module: conv_pass_sched

Interface
REQ-001 SHALL have parameter FW, default 4, width of the filter index and the filter count.
REQ-002 SHALL have parameter CW, default 4, width of the channel index and the channel count.
REQ-003 SHALL have parameter TIMEOUT, default 255, WAIT-state watchdog limit in cycles (used only with the macro).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  one-cycle request to begin a layer.
REQ-007 abort  input  1  synchronous cancel of the current layer.
REQ-008 num_filters  input  FW  filter count minus one.
REQ-009 num_channels  input  CW  input-channel count minus one.
REQ-010 conv_done  input  1  one-cycle pulse from the conv pass controller at the end of a pass.
REQ-011 conv_go  output  1  one-cycle pulse that launches one conv pass.
REQ-012 filt_bank  output  FW  current filter index.
REQ-013 chan_sel  output  CW  current input-channel index.
REQ-014 acc_keep  output  1  high to keep partial sums; high when chan_sel != 0.
REQ-015 wb_en  output  1  writeback enable; high when chan_sel == latched channel count.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle layer-complete pulse.
REQ-018 err  output  1  sticky watchdog error flag.

Function
REQ-019 SHALL implement the states IDLE, LAUNCH, WAIT, ADV and FIN; all outputs SHALL be registered or decoded from state only (Moore).
REQ-020 In IDLE, start=1 SHALL latch num_filters and num_channels, clear both indices and move to LAUNCH; later input changes SHALL be ignored until the next IDLE.
REQ-021 In LAUNCH, conv_go SHALL be 1 for exactly one cycle, then the block SHALL move to WAIT; conv_go SHALL be 1 in the cycle after start is sampled.
REQ-022 In WAIT, conv_done=1 SHALL move the block to ADV; conv_done SHALL be ignored in every other state.
REQ-023 In ADV, if chan_sel < the latched channel count, chan_sel SHALL increment and the block SHALL move to LAUNCH.
REQ-024 In ADV, if chan_sel equals the channel count and filt_bank < the filter count, chan_sel SHALL be 0, filt_bank SHALL increment and the block SHALL move to LAUNCH.
REQ-025 In ADV, if both indices are at their limits, the block SHALL move to FIN.
REQ-026 Pass order SHALL be channel-inner, filter-outer; the total number of conv_go pulses SHALL be (num_filters+1)*(num_channels+1).
REQ-027 conv_done at cycle t SHALL produce the next conv_go at cycle t+2.
REQ-028 FIN SHALL assert done for one cycle and then return to IDLE.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 abort=1 in any non-IDLE state SHALL return the block to IDLE on the next edge, with no done pulse and all indices 0.
REQ-031 If abort and conv_done occur in the same cycle, abort SHALL win; abort together with start in IDLE SHALL also win, and the block SHALL stay in IDLE.
REQ-032 Index arithmetic SHALL be unsigned; the indices SHALL never exceed the latched counts and SHALL never wrap.
REQ-033 Both counts at their maximum SHALL be supported (maximum value 2^FW-1 and 2^CW-1).

Reset
REQ-034 rst_n=0 SHALL force state IDLE immediately, and set conv_go, done, busy, acc_keep, wb_en, err, filt_bank and chan_sel to 0.
REQ-035 Reset mid-layer SHALL abandon the layer with no done pulse; operation SHALL resume on the first edge after rst_n rises.

Configuration
REQ-036 With SCHED_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT and clear on entry to WAIT.
REQ-037 With SCHED_TIMEOUT_EN defined, reaching TIMEOUT cycles without conv_done SHALL set err=1 and return the block to IDLE with no done pulse.
REQ-038 With SCHED_TIMEOUT_EN defined, err SHALL clear on the next accepted start.
REQ-039 Without SCHED_TIMEOUT_EN, there SHALL be no counter, err SHALL be constant 0, and WAIT SHALL wait indefinitely.

Verification
REQ-040 Single pass: counts 0/0, start at cycle 0 -> conv_go at cycle 1; conv_done at cycle 10 -> done at cycle 12; wb_en=1 and acc_keep=0 throughout.
REQ-041 Filters 1, channels 2 -> 6 conv_go pulses with (f,c) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); acc_keep = 0,1,1,0,1,1; wb_en high only at c=2.
REQ-042 Ignored inputs: start pulsed during WAIT -> no extra conv_go; conv_done in IDLE -> no state change and busy stays 0.
REQ-043 Abort during the second WAIT -> IDLE next cycle, busy=0, indices 0, no done; a new start -> conv_go one cycle later.
REQ-044 rst_n low mid-run -> all outputs 0 asynchronously; after release, start runs a full layer normally.
REQ-045 With SCHED_TIMEOUT_EN: no conv_done for 255 cycles -> err=1 and IDLE with no done; the next start -> err=0.
